// File: rtl/trace_capture.sv
// Per-lane issue trace buffer: circular capture while armed, programmable trigger,
// POST_TRIG further entries, then freeze and read out oldest-first over valid/ready.
// Define TRACE_TIMESTAMP_EN to append a free-running TS_W timestamp as the entry MSBs.
module trace_capture #(
    parameter int LANES     = 2,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int TS_W      = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_USED  = 1,
`else
    localparam int TS_USED  = 0,
`endif
    localparam int ENTRY_W  = LANES * 14 + TS_USED * TS_W,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 force_trig,
    input  logic [1:0]           trig_mode,
    input  logic [3:0]           trig_code,
    input  logic [LANES-1:0]     lane_valid,
    input  logic [LANES*4-1:0]   lane_instr,
    input  logic [LANES*5-1:0]   lane_alu,
    input  logic [LANES*4-1:0]   lane_haz,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [ENTRY_W-1:0]   rd_data,
    output logic                 rd_last,
    output logic [1:0]           state_o,
    output logic                 triggered,
    output logic [CNT_W-1:0]     count
);

    localparam int LANE_W = 14;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_TRIG);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt;
    logic [CNT_W-1:0]   count_nxt, post_cnt, remaining;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [LANES*LANE_W-1:0] lane_entry;
    logic [ENTRY_W-1:0]      entry;
    logic trig_hit, trig_event, capture, go_done, accept;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lane_entry = '0;
        trig_hit   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_entry[i*LANE_W +: LANE_W] = {lane_valid[i], lane_instr[i*4 +: 4],
                                              lane_alu[i*5 +: 5], lane_haz[i*4 +: 4]};
            if (lane_valid[i]) begin
                if (trig_mode[0] && lane_haz[i*4 +: 4] == trig_code)   trig_hit = 1'b1;
                if (trig_mode[1] && lane_instr[i*4 +: 4] == trig_code) trig_hit = 1'b1;
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + TS_W'(1);
    end

    assign entry = {ts, lane_entry};
`else
    assign entry = lane_entry;
`endif

    assign capture    = (state == S_ARMED || state == S_POST) && (|lane_valid);
    assign trig_event = (state == S_ARMED) && (force_trig || trig_hit);
    assign wr_ptr_nxt = capture ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign count_nxt  = (capture && count != DEPTH_C) ? count + ONE_C : count;
    assign go_done    = (trig_event && POST_TRIG == 0) ||
                        (state == S_POST && capture && post_cnt == ONE_C);
    assign rd_valid   = (state == S_DONE) && (remaining != '0);
    assign accept     = rd_valid && rd_ready;
    assign rd_last    = rd_valid && (remaining == ONE_C);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign state_o    = state;

    // NOTE: trace storage has no reset; count/remaining gate every read of it.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            remaining <= '0;
            triggered <= 1'b0;
        end else if (arm) begin
            state     <= S_ARMED;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            remaining <= '0;
            triggered <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
            if (go_done) begin
                // Oldest entry sits count positions behind the write pointer.
                state     <= S_DONE;
                rd_ptr    <= wr_ptr_nxt - count_nxt[PTR_W-1:0];
                remaining <= count_nxt;
            end
            case (state)
                S_ARMED: begin
                    if (trig_event) begin
                        triggered <= 1'b1;
                        post_cnt  <= POST_C;
                        if (POST_TRIG != 0) state <= S_POST;
                    end
                end
                S_POST: begin
                    if (capture) post_cnt <= post_cnt - ONE_C;
                end
                S_DONE: begin
                    if (remaining == '0) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        rd_ptr    <= rd_ptr + PTR_W'(1);
                        remaining <= remaining - ONE_C;
                        if (remaining == ONE_C) state <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: queue-based trace model compared every cycle,
// directed trigger/readout/arm/reset scenarios, then a randomized soak.
`timescale 1ns/1ps
module tb_trace_capture;

    localparam int LANES     = 2;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 8;
    localparam int TS_W      = 16;
    localparam int LANE_W    = 14;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W   = LANES * LANE_W + TS_W;
`else
    localparam int ENTRY_W   = LANES * LANE_W;
`endif
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int IW        = LANES * 4;
    localparam int AW        = LANES * 5;

    localparam int ST_IDLE = 0, ST_ARMED = 1, ST_POST = 2, ST_DONE = 3;

    logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, force_trig = 1'b0, rd_ready = 1'b0;
    logic [1:0]       trig_mode  = '0;
    logic [3:0]       trig_code  = '0;
    logic [LANES-1:0] lane_valid = '0;
    logic [IW-1:0]    lane_instr = '0;
    logic [AW-1:0]    lane_alu   = '0;
    logic [IW-1:0]    lane_haz   = '0;

    logic               rd_valid, rd_last, triggered;
    logic [ENTRY_W-1:0] rd_data;
    logic [1:0]         state_o;
    logic [CNT_W-1:0]   count;

    logic               p0_rd_valid, p0_rd_last, p0_triggered;
    logic [ENTRY_W-1:0] p0_rd_data;
    logic [1:0]         p0_state;
    logic [CNT_W-1:0]   p0_count;

    trace_capture #(.LANES(LANES), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .force_trig(force_trig),
        .trig_mode(trig_mode), .trig_code(trig_code), .lane_valid(lane_valid),
        .lane_instr(lane_instr), .lane_alu(lane_alu), .lane_haz(lane_haz),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .state_o(state_o), .triggered(triggered), .count(count)
    );

    trace_capture #(.LANES(LANES), .DEPTH(DEPTH), .POST_TRIG(0), .TS_W(TS_W)) dut_p0 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .force_trig(force_trig),
        .trig_mode(trig_mode), .trig_code(trig_code), .lane_valid(lane_valid),
        .lane_instr(lane_instr), .lane_alu(lane_alu), .lane_haz(lane_haz),
        .rd_valid(p0_rd_valid), .rd_ready(rd_ready), .rd_data(p0_rd_data), .rd_last(p0_rd_last),
        .state_o(p0_state), .triggered(p0_triggered), .count(p0_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                 m_st;
    bit                 m_trig;
    int                 m_post_left;
    int                 m_ts;
    logic [ENTRY_W-1:0] buf_q[$];
    logic [ENTRY_W-1:0] rd_q[$];

    function automatic logic [ENTRY_W-1:0] make_entry(input int ts);
        logic [ENTRY_W-1:0] e;
        e = '0;
        for (int i = 0; i < LANES; i++)
            e[i*LANE_W +: LANE_W] = {lane_valid[i], lane_instr[i*4 +: 4],
                                     lane_alu[i*5 +: 5], lane_haz[i*4 +: 4]};
`ifdef TRACE_TIMESTAMP_EN
        e[ENTRY_W-1 -: TS_W] = TS_W'(ts);
`endif
        return e;
    endfunction

    function automatic bit pattern_match();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid[i]) begin
                if ((trig_mode == 2'b01 || trig_mode == 2'b11) && lane_haz[i*4 +: 4] == trig_code)
                    hit = 1'b1;
                if ((trig_mode == 2'b10 || trig_mode == 2'b11) && lane_instr[i*4 +: 4] == trig_code)
                    hit = 1'b1;
            end
        end
        return hit;
    endfunction

    task automatic m_reset();
        m_st = ST_IDLE; m_trig = 1'b0; m_post_left = 0; m_ts = 0;
        buf_q.delete(); rd_q.delete();
    endtask

    task automatic model_step();
        bit cap, ev;
        cap = (m_st == ST_ARMED || m_st == ST_POST) && (lane_valid != '0);
        ev  = (m_st == ST_ARMED) && (force_trig || pattern_match());
        if (arm) begin
            m_st = ST_ARMED; m_trig = 1'b0;
            buf_q.delete(); rd_q.delete();
        end else begin
            if (cap) begin
                buf_q.push_back(make_entry(m_ts));
                if (buf_q.size() > DEPTH) void'(buf_q.pop_front());
            end
            case (m_st)
                ST_ARMED: if (ev) begin
                    m_trig = 1'b1;
                    m_post_left = POST_TRIG;
                    if (m_post_left == 0) begin m_st = ST_DONE; rd_q = buf_q; end
                    else m_st = ST_POST;
                end
                ST_POST: if (cap) begin
                    m_post_left--;
                    if (m_post_left == 0) begin m_st = ST_DONE; rd_q = buf_q; end
                end
                ST_DONE: begin
                    if (rd_q.size() == 0) m_st = ST_IDLE;
                    else if (rd_ready) begin
                        void'(rd_q.pop_front());
                        if (rd_q.size() == 0) m_st = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
        m_ts++;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = (m_st == ST_DONE) && (rd_q.size() > 0);
            check("state", 64'(state_o), 64'(m_st));
            check("triggered", 64'(triggered), 64'(m_trig));
            check("count", 64'(count), 64'(buf_q.size()));
            check("rd_valid", 64'(rd_valid), 64'(ev));
            check("rd_last", 64'(rd_last), 64'(ev && rd_q.size() == 1));
            check("rd_data", 64'(rd_data), ev ? 64'(rd_q[0]) : 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm = 1'b0; force_trig = 1'b0; lane_valid = '0;
        lane_instr = '0; lane_alu = '0; lane_haz = '0; rd_ready = 1'b0;
    endtask

    task automatic rand_lanes();
        lane_valid = LANES'($urandom_range(1, (1 << LANES) - 1));
        lane_instr = IW'($urandom) & IW'({LANES{4'h7}});
        lane_alu   = AW'($urandom);
        lane_haz   = IW'($urandom) & IW'({LANES{4'h7}});
    endtask

    task automatic readout(input bit toggle, input int n_exp);
        int acc;
        bit stalled;
        logic [ENTRY_W-1:0] held;
        acc = 0; stalled = 1'b0; held = '0;
        for (int k = 0; k < 4 * DEPTH + 8 && acc < n_exp; k++) begin
            rd_ready = toggle ? ~k[0] : 1'b1;
            if (stalled) check("hold_stable", 64'(rd_data), 64'(held));
            stalled = rd_valid && !rd_ready;
            held    = rd_data;
            if (rd_valid && rd_ready) begin
                acc++;
                check("last_on_final", 64'(rd_last), 64'(acc == n_exp));
            end
            step();
        end
        rd_ready = 1'b0;
        check("accept_total", 64'(acc), 64'(n_exp));
        check("idle_after_read", 64'(state_o), 64'(ST_IDLE));
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        step();

        // Hazard trigger: A_STALL on lane 1 at cycle 12 of 20, then 8 post captures.
        trig_mode = 2'b01; trig_code = 4'h0;
        arm = 1'b1; step(); arm = 1'b0;
        check("t1_armed", 64'(state_o), 64'(ST_ARMED));
        for (int c = 1; c <= 20; c++) begin
            lane_valid = 2'b11;
            lane_instr = {4'h3, 4'h1};
            lane_alu   = {5'(c + 10), 5'(c)};
            lane_haz   = {(c == 12) ? 4'h0 : 4'h3, 4'h1};
            step();
            if (c == 12) check("t1_post", 64'(state_o), 64'(ST_POST));
        end
        idle_inputs();
        check("t1_done", 64'(state_o), 64'(ST_DONE));
        check("t1_count16", 64'(count), 64'd16);
        check("t1_oldest_alu", 64'(rd_data[8:4]), 64'd5);
        check("t1_oldest_lane1", 64'(rd_data[27:14]), 64'({1'b1, 4'h3, 5'd15, 4'h3}));
        readout(1'b1, 16);

        // Instruction-type trigger (LOAD_i), invalid lane carrying the code must not fire.
        trig_mode = 2'b10; trig_code = 4'h2;
        arm = 1'b1; step(); arm = 1'b0;
        for (int c = 0; c < 3; c++) begin
            lane_valid = 2'b01; lane_instr = {4'h2, 4'h3}; lane_alu = AW'($urandom);
            lane_haz = '0; step();
        end
        check("t3_no_false_trig", 64'(state_o), 64'(ST_ARMED));
        lane_valid = 2'b10; lane_instr = {4'h2, 4'h5}; step();
        check("t3_trig", 64'(triggered), 64'd1);
        for (int c = 0; c < 9; c++) begin
            if (c == 4) lane_valid = '0; else rand_lanes();
            step();
        end
        idle_inputs();
        check("t3_count12", 64'(count), 64'd12);
        readout(1'b0, 12);

        // POST_TRIG = 0 variant, forced trigger on an empty buffer.
        arm = 1'b1; step(); arm = 1'b0;
        force_trig = 1'b1; lane_valid = '0; step(); force_trig = 1'b0;
        check("p0_done", 64'(p0_state), 64'(ST_DONE));
        check("p0_no_valid_a", 64'(p0_rd_valid), 64'd0);
        check("p0_count0", 64'(p0_count), 64'd0);
        step();
        check("p0_idle", 64'(p0_state), 64'(ST_IDLE));
        check("p0_no_valid_b", 64'(p0_rd_valid), 64'd0);

        // Manual mode ignores pattern matches; arm abandons readout after 5 accepts.
        trig_mode = 2'b00; trig_code = 4'h1;
        arm = 1'b1; step(); arm = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            rand_lanes();
            lane_haz = {LANES{4'h1}};
            force_trig = (c == 10);
            step();
            if (c == 9) check("t5_manual_only", 64'(state_o), 64'(ST_ARMED));
        end
        idle_inputs();
        check("t5_done", 64'(state_o), 64'(ST_DONE));
        rd_ready = 1'b1;
        repeat (5) step();
        arm = 1'b1; step(); arm = 1'b0; rd_ready = 1'b0;
        check("t5_rd_valid", 64'(rd_valid), 64'd0);
        check("t5_armed", 64'(state_o), 64'(ST_ARMED));
        check("t5_count0", 64'(count), 64'd0);
        check("t5_untrig", 64'(triggered), 64'd0);

        // Asynchronous reset while in POST.
        force_trig = 1'b1; rand_lanes(); step(); force_trig = 1'b0;
        rand_lanes(); step();
        check("t6_in_post", 64'(state_o), 64'(ST_POST));
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("t6_state", 64'(state_o), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_trig", 64'(triggered), 64'd0);
        check("t6_rd_valid", 64'(rd_valid), 64'd0);
        check("t6_rd_last", 64'(rd_last), 64'd0);
        check("t6_rd_data", 64'(rd_data), 64'd0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        arm = 1'b1; step(); arm = 1'b0;
        force_trig = 1'b1; rand_lanes(); step(); force_trig = 1'b0;
        for (int c = 0; c < POST_TRIG; c++) begin rand_lanes(); step(); end
        idle_inputs();
        check("t6_count9", 64'(count), 64'(POST_TRIG + 1));
`ifdef TRACE_TIMESTAMP_EN
        check("t6_first_ts", 64'(rd_data[ENTRY_W-1 -: TS_W]), 64'd1);
`endif
        readout(1'b0, POST_TRIG + 1);

        // Randomized soak.
        for (int n = 0; n < 3000; n++) begin
            arm        = ($urandom_range(0, 40) == 0);
            force_trig = ($urandom_range(0, 25) == 0);
            trig_mode  = 2'($urandom);
            trig_code  = 4'($urandom_range(0, 3));
            rand_lanes();
            if ($urandom_range(0, 3) == 0) lane_valid = '0;
            rd_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
